dmem_bridge: RTL and testbench

- Memory-stage responder for the pipeline's data-memory controls (memen/memwrite in M stage).
- Turns one M-stage load/store into a transaction on a split address/data handshake bus (addr_ok/data_ok).
- Generates byte strobes, load alignment and extension, and address-error flags.
- Drives a stall request back to the hazard unit while a transaction is outstanding.

---
 rtl/dmem_bridge.sv | 140 ++++++++++++++
 tb/tb_dmem_bridge.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bridge.sv
// M-stage data-memory responder: turns one load/store into an addr_ok/data_ok
// bus transaction, with strobes, load extension, address errors and stall.
module dmem_bridge #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          memenM,
   input  logic          memwriteM,
   input  logic [AW-1:0] addrM,
   input  logic [DW-1:0] wdataM,
   input  logic [1:0]    sizeM,
   input  logic          signedM,
   input  logic          flushM,
   input  logic          stall_other,
   output logic          data_req,
   output logic          data_wr,
   output logic [AW-1:0] data_addr,
   output logic [3:0]    data_wstrb,
   output logic [DW-1:0] data_wdata,
   input  logic          data_addr_ok,
   input  logic          data_data_ok,
   input  logic [DW-1:0] data_rdata,
   output logic [DW-1:0] rdataM,
   output logic          stallM,
   output logic          adelM,
   output logic          adesM,
   output logic [AW-1:0] badvaddrM
);

   typedef enum logic [2:0] {IDLE, ADDR, DATA, DONE, DRAIN} state_t;

   state_t        state, state_n;
   logic          misaligned, access_ok, valid, issue, killed, capture;
   logic [AW-1:0] r_addr;
   logic [1:0]    r_size;
   logic          r_signed, r_wr;
   logic [3:0]    r_wstrb, wstrb_in;
   logic [DW-1:0] r_wdata, wdata_in, load_ext;
   logic [7:0]    byte_v;
   logic [15:0]   half_v;

   assign misaligned = (sizeM == 2'b01 && addrM[0]) || (sizeM[1] && addrM[1:0] != 2'b00);
   assign access_ok  = memenM & ~flushM;
   assign valid      = access_ok & ~misaligned;
   assign adelM      = access_ok & misaligned & ~memwriteM;
   assign adesM      = access_ok & misaligned & memwriteM;
   assign badvaddrM  = addrM;
   assign issue      = (state == IDLE) && valid;
   assign capture    = (state == DATA) && data_data_ok && !flushM && !r_wr;

   always_comb begin
      wstrb_in = 4'b0000;
      wdata_in = wdataM;
      case (sizeM)
         2'b00: begin
            wstrb_in = 4'b0001 << addrM[1:0];
            wdata_in = {4{wdataM[7:0]}};
         end
         2'b01: begin
            wstrb_in = addrM[1] ? 4'b1100 : 4'b0011;
            wdata_in = {2{wdataM[15:0]}};
         end
         default: wstrb_in = 4'b1111;
      endcase
      if (!memwriteM) wstrb_in = 4'b0000;
   end

   // Extraction uses the latched request; the M-stage inputs may have moved on.
   always_comb begin
      case (r_addr[1:0])
         2'd0:    byte_v = data_rdata[7:0];
         2'd1:    byte_v = data_rdata[15:8];
         2'd2:    byte_v = data_rdata[23:16];
         default: byte_v = data_rdata[31:24];
      endcase
      half_v = r_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
      case (r_size)
         2'b00:   load_ext = {{24{r_signed & byte_v[7]}}, byte_v};
         2'b01:   load_ext = {{16{r_signed & half_v[15]}}, half_v};
         default: load_ext = data_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:  if (valid) state_n = data_addr_ok ? DATA : ADDR;
         ADDR:  if (data_addr_ok) state_n = (killed || flushM) ? DRAIN : DATA;
         DATA: begin
            if (flushM)            state_n = data_data_ok ? IDLE : DRAIN;
            else if (data_data_ok) state_n = DONE;
         end
         DONE:  if (!stall_other) state_n = IDLE;
         DRAIN: if (data_data_ok) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      data_req   = issue || state == ADDR;
      stallM     = issue || state == ADDR || state == DATA || state == DRAIN;
      data_wr    = issue ? memwriteM : r_wr;
      data_addr  = issue ? {addrM[AW-1:2], 2'b00} : {r_addr[AW-1:2], 2'b00};
      data_wstrb = issue ? wstrb_in : r_wstrb;
      data_wdata = issue ? wdata_in : r_wdata;
   end

   // A flush seen while waiting for addr_ok must survive until acceptance.
   always_ff @(posedge clk) begin
      if (!rst) begin
         killed   <= 1'b0;
         r_addr   <= '0;
         r_size   <= 2'b00;
         r_signed <= 1'b0;
         r_wr     <= 1'b0;
         r_wstrb  <= 4'b0000;
         r_wdata  <= '0;
         rdataM   <= '0;
      end else begin
         killed <= (state == ADDR) && !data_addr_ok && (killed || flushM);
         if (issue) begin
            r_addr   <= addrM;
            r_size   <= sizeM;
            r_signed <= signedM;
            r_wr     <= memwriteM;
            r_wstrb  <= wstrb_in;
            r_wdata  <= wdata_in;
         end
         if (capture) rdataM <= load_ext;
      end
   end

endmodule

// File: tb/tb_dmem_bridge.sv
// Randomized and directed bench for dmem_bridge against an arithmetic model of
// strobes, lane replication, load extension, misalignment and handshake timing.
module tb_dmem_bridge;
   localparam int AW = 32;

   logic          clk = 1'b0, rst = 1'b0;
   logic          memenM = 0, memwriteM = 0, signedM = 0, flushM = 0, stall_other = 0;
   logic [AW-1:0] addrM = '0;
   logic [31:0]   wdataM = '0;
   logic [1:0]    sizeM = '0;
   logic          data_req, data_wr, data_addr_ok = 0, data_data_ok = 0;
   logic [AW-1:0] data_addr, badvaddrM;
   logic [3:0]    data_wstrb;
   logic [31:0]   data_wdata, data_rdata = '0, rdataM;
   logic          stallM, adelM, adesM;

   dmem_bridge #(.AW(AW), .DW(32)) dut (
      .clk(clk), .rst(rst), .memenM(memenM), .memwriteM(memwriteM), .addrM(addrM),
      .wdataM(wdataM), .sizeM(sizeM), .signedM(signedM), .flushM(flushM),
      .stall_other(stall_other), .data_req(data_req), .data_wr(data_wr),
      .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .rdataM(rdataM), .stallM(stallM), .adelM(adelM), .adesM(adesM), .badvaddrM(badvaddrM)
   );

   always #5 clk = ~clk;

   int          n_checks = 0, n_fail = 0;
   logic [31:0] exp_rd = '0;

   // observations from the last run_txn
   int          o_req, o_stall;
   logic        o_tmo, o_stable, o_adel, o_ades, o_wr;
   logic [31:0] o_bad, o_addr, o_wdata, o_rd;
   logic [3:0]  o_strb;

   function automatic bit m_mis(logic [31:0] a, logic [1:0] s);
      if (s == 2'd1) return (a % 2) != 0;
      if (s >= 2'd2) return (a % 4) != 0;
      return 1'b0;
   endfunction

   function automatic logic [3:0] m_strb(logic [31:0] a, logic [1:0] s, logic wr);
      if (!wr) return 4'h0;
      if (s == 2'd0) return 4'(1 << (a % 4));
      if (s == 2'd1) return ((a % 4) >= 2) ? 4'hC : 4'h3;
      return 4'hF;
   endfunction

   function automatic logic [31:0] m_wdata(logic [31:0] d, logic [1:0] s);
      if (s == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
      if (s == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] m_load(logic [31:0] rd, logic [31:0] a, logic [1:0] s, logic sg);
      logic [31:0] v;
      if (s == 2'd0) begin
         v = (rd >> (8 * (a % 4))) & 32'hFF;
         if (sg && v >= 128) v = v + 32'hFFFF_FF00;
      end else if (s == 2'd1) begin
         v = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
         if (sg && v >= 32768) v = v + 32'hFFFF_0000;
      end else v = rd;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one M-stage access and plays the bus: addr_ok after a_dly request
   // cycles, data_ok d_dly cycles after acceptance. Records what it observes.
   task automatic run_txn(input logic en, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [1:0] s, input logic sg,
                          input logic fl, input int a_dly, input int d_dly,
                          input logic [31:0] rd);
      memenM = en; memwriteM = wr; addrM = a; wdataM = wd; sizeM = s;
      signedM = sg; flushM = fl;
      o_req = 0; o_stall = 0; o_tmo = 1'b1; o_stable = 1'b1;
      o_addr = '0; o_wdata = '0; o_strb = '0; o_wr = 1'b0; o_rd = '0;
      for (int k = 0; k < 40; k++) begin
         data_addr_ok = (k == a_dly);
         data_data_ok = (k == a_dly + 1 + d_dly);
         data_rdata   = data_data_ok ? rd : $urandom;
         @(negedge clk);
         if (k == 0) begin
            o_adel = adelM; o_ades = adesM; o_bad = badvaddrM;
         end
         if (data_req) begin
            if (o_req == 0) begin
               o_addr = data_addr; o_wdata = data_wdata; o_strb = data_wstrb; o_wr = data_wr;
            end else if (o_addr !== data_addr || o_wdata !== data_wdata ||
                         o_strb !== data_wstrb || o_wr !== data_wr) o_stable = 1'b0;
            o_req++;
         end
         if (stallM) o_stall++;
         else begin
            o_rd = rdataM;
            o_tmo = 1'b0;
         end
         tick();
         if (!o_tmo) break;
      end
      memenM = 0; flushM = 0; data_addr_ok = 0; data_data_ok = 0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      tick();
      @(negedge clk);
      n_checks++; if (data_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", data_req); end
      n_checks++; if (stallM !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stallM); end
      n_checks++; if (rdataM !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdataM); end
      n_checks++; if ({data_wr, data_wstrb, data_addr, data_wdata} !== '0) begin
         n_fail++; $display("FAIL reset_bus: got wr=%b strb=%h addr=%h wdata=%h want all 0",
                            data_wr, data_wstrb, data_addr, data_wdata);
      end
      tick();
      rst = 1'b1;
      exp_rd = '0;
   endtask

   task automatic test_word_load();
      run_txn(1, 0, 32'h100, 32'h0, 2'd2, 0, 0, 0, 0, 32'hDEAD_BEEF);
      exp_rd = 32'hDEAD_BEEF;
      n_checks++; if (o_tmo !== 1'b0) begin n_fail++; $display("FAIL wl_timeout: transaction never completed"); end
      n_checks++; if (o_stall != 2) begin n_fail++; $display("FAIL wl_stall_cycles: got %0d want 2", o_stall); end
      n_checks++; if (o_req != 1) begin n_fail++; $display("FAIL wl_req_cycles: got %0d want 1", o_req); end
      n_checks++; if (o_addr !== 32'h100) begin n_fail++; $display("FAIL wl_addr: got %h want 100", o_addr); end
      n_checks++; if (o_strb !== 4'h0) begin n_fail++; $display("FAIL wl_strb: got %h want 0", o_strb); end
      n_checks++; if (o_rd !== exp_rd) begin n_fail++; $display("FAIL wl_rdata: got %h want %h", o_rd, exp_rd); end
   endtask

   task automatic test_byte_load();
      run_txn(1, 0, 32'h103, 32'h0, 2'd0, 1, 0, 0, 1, 32'h80FF_1234);
      n_checks++; if (o_rd !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_signed: got %h want ffffff80", o_rd); end
      run_txn(1, 0, 32'h103, 32'h0, 2'd0, 0, 0, 1, 0, 32'h80FF_1234);
      exp_rd = 32'h0000_0080;
      n_checks++; if (o_rd !== exp_rd) begin n_fail++; $display("FAIL lb_unsigned: got %h want %h", o_rd, exp_rd); end
   endtask

   task automatic test_half_store();
      run_txn(1, 1, 32'h102, 32'h0000_ABCD, 2'd1, 0, 0, 3, 1, 32'h5555_5555);
      n_checks++; if (o_req != 4 || o_stable !== 1'b1) begin
         n_fail++; $display("FAIL sh_req_hold: got %0d cycles stable=%b want 4 stable=1", o_req, o_stable);
      end
      n_checks++; if (o_addr !== 32'h100 || o_wr !== 1'b1) begin
         n_fail++; $display("FAIL sh_addr: got %h wr=%b want 100 wr=1", o_addr, o_wr);
      end
      n_checks++; if (o_strb !== 4'b1100) begin n_fail++; $display("FAIL sh_strb: got %b want 1100", o_strb); end
      n_checks++; if (o_wdata !== 32'hABCD_ABCD) begin n_fail++; $display("FAIL sh_wdata: got %h want abcdabcd", o_wdata); end
      n_checks++; if (o_stall != 6) begin n_fail++; $display("FAIL sh_stall_cycles: got %0d want 6", o_stall); end
      n_checks++; if (o_rd !== exp_rd) begin n_fail++; $display("FAIL sh_rdata_kept: got %h want %h", o_rd, exp_rd); end
   endtask

   task automatic test_misaligned();
      run_txn(1, 0, 32'h101, 32'h0, 2'd2, 0, 0, 0, 0, 32'h0);
      n_checks++; if (o_adel !== 1'b1 || o_ades !== 1'b0) begin
         n_fail++; $display("FAIL mis_adel: got adel=%b ades=%b want 1/0", o_adel, o_ades);
      end
      n_checks++; if (o_bad !== 32'h101) begin n_fail++; $display("FAIL mis_badvaddr: got %h want 101", o_bad); end
      n_checks++; if (o_req != 0 || o_stall != 0) begin
         n_fail++; $display("FAIL mis_no_bus: got req=%0d stall=%0d want 0/0", o_req, o_stall);
      end
      run_txn(1, 1, 32'h203, 32'h1234, 2'd1, 0, 0, 0, 0, 32'h0);
      n_checks++; if (o_ades !== 1'b1 || o_adel !== 1'b0 || o_req != 0) begin
         n_fail++; $display("FAIL mis_ades: got ades=%b adel=%b req=%0d want 1/0/0", o_ades, o_adel, o_req);
      end
   endtask

   task automatic test_flush();
      memenM = 1; memwriteM = 0; addrM = 32'h40; sizeM = 2'd2; signedM = 0; data_addr_ok = 1;
      @(negedge clk);
      n_checks++; if (stallM !== 1'b1) begin n_fail++; $display("FAIL fl_issue_stall: got %b want 1", stallM); end
      tick();
      data_addr_ok = 0; flushM = 1;
      @(negedge clk);
      n_checks++; if (stallM !== 1'b1 || data_req !== 1'b0) begin
         n_fail++; $display("FAIL fl_data: got stall=%b req=%b want 1/0", stallM, data_req);
      end
      tick();
      flushM = 0; memenM = 0;
      @(negedge clk);
      n_checks++; if (stallM !== 1'b1 || data_req !== 1'b0) begin
         n_fail++; $display("FAIL fl_drain: got stall=%b req=%b want 1/0", stallM, data_req);
      end
      tick();
      data_data_ok = 1; data_rdata = 32'h1234_5678;
      @(negedge clk);
      n_checks++; if (stallM !== 1'b1) begin n_fail++; $display("FAIL fl_drain_ok_stall: got %b want 1", stallM); end
      tick();
      data_data_ok = 0;
      @(negedge clk);
      n_checks++; if (stallM !== 1'b0 || data_req !== 1'b0) begin
         n_fail++; $display("FAIL fl_idle: got stall=%b req=%b want 0/0", stallM, data_req);
      end
      n_checks++; if (rdataM !== exp_rd) begin n_fail++; $display("FAIL fl_rdata_kept: got %h want %h", rdataM, exp_rd); end
      tick();
   endtask

   task automatic test_stall_other();
      memenM = 1; memwriteM = 0; addrM = 32'h208; sizeM = 2'd2; data_addr_ok = 1;
      tick();
      data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h0BAD_F00D;
      tick();
      data_data_ok = 0; data_rdata = 32'hFFFF_FFFF; stall_other = 1;
      exp_rd = 32'h0BAD_F00D;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++; if (rdataM !== exp_rd || data_req !== 1'b0 || stallM !== 1'b0) begin
            n_fail++; $display("FAIL so_done[%0d]: got rdata=%h req=%b stall=%b want %h/0/0",
                               i, rdataM, data_req, stallM, exp_rd);
         end
         tick();
      end
      stall_other = 0; memenM = 0;
      @(negedge clk);
      n_checks++; if (data_req !== 1'b0 || rdataM !== exp_rd) begin
         n_fail++; $display("FAIL so_release: got req=%b rdata=%h want 0/%h", data_req, rdataM, exp_rd);
      end
      tick();
      @(negedge clk);
      n_checks++; if (data_req !== 1'b0 || stallM !== 1'b0) begin
         n_fail++; $display("FAIL so_no_reissue: got req=%b stall=%b want 0/0", data_req, stallM);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      memenM = 1; memwriteM = 1; addrM = 32'h300; wdataM = 32'h7777_7777; sizeM = 2'd2;
      tick();
      rst = 0;
      @(negedge clk);
      n_checks++; if (data_req !== 1'b1) begin n_fail++; $display("FAIL rm_addr_wait: got req=%b want 1", data_req); end
      tick();
      rst = 1; memenM = 0; memwriteM = 0; data_data_ok = 1; data_rdata = 32'hCAFE_F00D;
      exp_rd = '0;
      @(negedge clk);
      n_checks++; if (data_req !== 1'b0 || stallM !== 1'b0 || rdataM !== 32'h0) begin
         n_fail++; $display("FAIL rm_cleared: got req=%b stall=%b rdata=%h want 0/0/0", data_req, stallM, rdataM);
      end
      n_checks++; if ({data_wr, data_wstrb, data_addr, data_wdata} !== '0) begin
         n_fail++; $display("FAIL rm_bus: got wr=%b strb=%h addr=%h wdata=%h want all 0",
                            data_wr, data_wstrb, data_addr, data_wdata);
      end
      tick();
      data_data_ok = 0;
      @(negedge clk);
      n_checks++; if (rdataM !== exp_rd || stallM !== 1'b0) begin
         n_fail++; $display("FAIL rm_late_ok: got rdata=%h stall=%b want %h/0", rdataM, stallM, exp_rd);
      end
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 80; i++) begin
         logic        en, wr, sg, fl, vld, mis;
         logic [31:0] a, wd, rd;
         logic [1:0]  s;
         int          ad, dd;
         en = ($urandom % 6) != 0; wr = $urandom % 2; sg = $urandom % 2; fl = ($urandom % 8) == 0;
         a = $urandom; wd = $urandom; rd = $urandom; s = 2'($urandom % 4);
         ad = $urandom_range(0, 3); dd = $urandom_range(0, 3);
         mis = m_mis(a, s);
         vld = en && !fl && !mis;
         run_txn(en, wr, a, wd, s, sg, fl, ad, dd, rd);
         if (vld && !wr) exp_rd = m_load(rd, a, s, sg);
         n_checks++; if (o_tmo !== 1'b0) begin n_fail++; $display("FAIL rnd_timeout[%0d]", i); end
         n_checks++; if (o_adel !== (en && !fl && mis && !wr) || o_ades !== (en && !fl && mis && wr)) begin
            n_fail++; $display("FAIL rnd_adex[%0d]: got adel=%b ades=%b a=%h s=%0d", i, o_adel, o_ades, a, s);
         end
         n_checks++; if (o_req != (vld ? ad + 1 : 0) || o_stall != (vld ? ad + dd + 2 : 0)) begin
            n_fail++; $display("FAIL rnd_timing[%0d]: got req=%0d stall=%0d want %0d/%0d", i,
                               o_req, o_stall, vld ? ad + 1 : 0, vld ? ad + dd + 2 : 0);
         end
         if (vld) begin
            n_checks++; if (o_addr !== (a & 32'hFFFF_FFFC) || o_wr !== wr || o_stable !== 1'b1) begin
               n_fail++; $display("FAIL rnd_addr[%0d]: got %h wr=%b stable=%b want %h wr=%b", i,
                                  o_addr, o_wr, o_stable, a & 32'hFFFF_FFFC, wr);
            end
            n_checks++; if (o_strb !== m_strb(a, s, wr)) begin
               n_fail++; $display("FAIL rnd_strb[%0d]: got %h want %h", i, o_strb, m_strb(a, s, wr));
            end
            if (wr) begin
               n_checks++; if (o_wdata !== m_wdata(wd, s)) begin
                  n_fail++; $display("FAIL rnd_wdata[%0d]: got %h want %h", i, o_wdata, m_wdata(wd, s));
               end
            end
         end
         n_checks++; if (o_rd !== exp_rd) begin
            n_fail++; $display("FAIL rnd_rdata[%0d]: got %h want %h (a=%h s=%0d sg=%b)", i, o_rd, exp_rd, a, s, sg);
         end
      end
   endtask

   initial begin
      test_reset();
      test_word_load();
      test_byte_load();
      test_half_store();
      test_misaligned();
      test_flush();
      test_stall_other();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
